fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_q.sv | 69 ++++++
 rtl/fetch.sv | 143 ++++++++++++++
 tb/tb_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared core definitions: fetch FSM state encoding and default datapath width.
// Decode/execute import this package so they agree with fetch on both.
package fetch_pkg;

    localparam int RV_DEFAULT = 32;
    localparam int ILEN       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_q.sv
// Prefetch queue: power-of-two FIFO with synchronous flush.
// A push and a pop in the same cycle are legal even when full.
module fetch_q #(
    parameter int W     = 48,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot being written, so a full queue may still accept a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !reset_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding halfword request, prefetch queue to decode,
// and redirect handling that drains an in-flight request in KILL before refetching.
module fetch
    import fetch_pkg::*;
#(
    parameter int            RV       = RV_DEFAULT,
    parameter logic [RV-1:0] RESET_PC = {RV{1'b0}},
    parameter int            QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [RV-1:0]     redirect_pc,
    output logic              ifetch_req,
    output logic [RV-1:0]     ifetch_addr,
    input  logic              ifetch_ack,
    input  logic [ILEN-1:0]   ifetch_data,
    output logic [ILEN-1:0]   ins,
    output logic              idone,
    output logic [RV-1:0]     ins_pc,
    output fetch_state_e      dbg_state_o
);

    localparam int QW = ILEN + RV;
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [RV-1:0] fetch_pc_q, fetch_pc_d;
    logic [RV-1:0] kill_addr_q, kill_addr_d;

    logic [RV-1:0] redirect_tgt;
    logic [RV-1:0] pc_inc;
    logic          launch;
    logic          active_req;
    logic          push;
    logic          pop;
    logic          keep_going;
    logic [CW-1:0] cnt_after;

    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic [QW-1:0] q_rdata;

    assign redirect_tgt = redirect_pc & ~RV'(1);
    assign pc_inc       = fetch_pc_q + RV'(2);

    // IDLE issues combinationally so the first request leaves in the first cycle out of reset.
    assign launch     = (state_q == ST_IDLE) && !q_full && !redirect;
    assign active_req = launch || (state_q == ST_REQ);

    assign ifetch_req  = !reset && (active_req || (state_q == ST_KILL));
    assign ifetch_addr = (state_q == ST_KILL) ? kill_addr_q : fetch_pc_q;

    // Valid/ready: a halfword transfers on any cycle with ifetch_req && ifetch_ack;
    // toward decode, idone is a strobe and stall is the only back-pressure.
    assign push  = !reset && active_req && ifetch_ack && !redirect;
    assign pop   = !reset && !q_empty && !stall && !redirect;
    assign idone = pop;

    assign cnt_after  = q_count + CW'(push) - CW'(pop);
    assign keep_going = (cnt_after < CW'(QDEPTH));

    assign ins         = q_rdata[QW-1:RV];
    assign ins_pc      = q_rdata[RV-1:0];
    assign dbg_state_o = state_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        kill_addr_d = kill_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                end else if (!q_full) begin
                    if (ifetch_ack) begin
                        fetch_pc_d = pc_inc;
                        state_d    = keep_going ? ST_REQ : ST_IDLE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                    if (ifetch_ack) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_KILL;
                        kill_addr_d = fetch_pc_q;
                    end
                end else if (ifetch_ack) begin
                    fetch_pc_d = pc_inc;
                    state_d    = keep_going ? ST_REQ : ST_IDLE;
                end
            end
            ST_KILL: begin
                // The stale request must still complete; its data is dropped.
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                end
                if (ifetch_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            kill_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            kill_addr_q <= kill_addr_d;
        end
    end

    fetch_q #(
        .W     (QW),
        .DEPTH (QDEPTH)
    ) u_fetch_q (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({ifetch_data, fetch_pc_q}),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: reset, streaming, stall back-pressure, redirects, PC wrap.
module tb_fetch;
    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall = 1'b0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         ifetch_req;
    logic [31:0]  ifetch_addr;
    logic         ifetch_ack = 1'b0;
    logic [15:0]  ifetch_data = '0;
    logic [15:0]  ins;
    logic         idone;
    logic [31:0]  ins_pc;
    fetch_state_e dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int mem_lat = 0;
    int wait_cnt = 0;
    logic [31:0] exp_q[$];

    fetch #(
        .RV       (32),
        .RESET_PC (32'h0000_0100),
        .QDEPTH   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifetch_req  (ifetch_req),
        .ifetch_addr (ifetch_addr),
        .ifetch_ack  (ifetch_ack),
        .ifetch_data (ifetch_data),
        .ins         (ins),
        .idone       (idone),
        .ins_pc      (ins_pc),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'hBEEF;
    endfunction

    // Memory: acks a held request after mem_lat idle cycles; never acks during reset.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset || !ifetch_req) begin
                ifetch_ack  = 1'b0;
                ifetch_data = '0;
                wait_cnt    = 0;
            end else if (wait_cnt >= mem_lat) begin
                ifetch_ack  = 1'b1;
                ifetch_data = mem_word(ifetch_addr);
                wait_cnt    = 0;
            end else begin
                ifetch_ack  = 1'b0;
                ifetch_data = '0;
                wait_cnt    = wait_cnt + 1;
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        reset       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        #2;
    endtask

    task automatic do_reset();
        mem_lat = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        mem_lat = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++; if (ifetch_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", ifetch_req); end
        n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL rst_idone: got %0b want 0", idone); end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (ifetch_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %0b want 1", ifetch_req); end
        n_vec++; if (ifetch_addr !== 32'h100) begin n_err++; $display("FAIL first_addr: got %h want 00000100", ifetch_addr); end
        n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL first_idone: got %0b want 0", idone); end
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            pc = 32'h100 + 32'(2 * k);
            step(1'b0, 1'b0, 1'b0, 32'h0);
            n_vec++; if (idone !== 1'b1) begin n_err++; $display("FAIL stream_idone%0d: got %0b want 1", k, idone); end
            n_vec++; if (ins_pc !== pc) begin n_err++; $display("FAIL stream_pc%0d: got %h want %h", k, ins_pc, pc); end
            n_vec++; if (ins !== mem_word(pc)) begin n_err++; $display("FAIL stream_ins%0d: got %h want %h", k, ins, mem_word(pc)); end
        end
    endtask

    task automatic test_stall();
        logic        exp_req;
        logic [31:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            exp_req = (c <= 2);
            step(1'b0, 1'b1, 1'b0, 32'h0);
            n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL stall_idone%0d: got %0b want 0", c, idone); end
            n_vec++; if (ifetch_req !== exp_req) begin n_err++; $display("FAIL stall_req%0d: got %0b want %0b", c, ifetch_req, exp_req); end
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h100 + 32'(2 * k));
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            n_vec++; if (idone !== 1'b1) begin n_err++; $display("FAIL release_idone%0d: got %0b want 1", k, idone); end
            if (idone === 1'b1 && exp_q.size() > 0) begin
                exp_pc = exp_q.pop_front();
                n_vec++; if (ins_pc !== exp_pc) begin n_err++; $display("FAIL release_pc%0d: got %h want %h", k, ins_pc, exp_pc); end
            end
        end
        n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL release_lost: got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_redirect_kill();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        mem_lat = 4;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (ins_pc !== 32'h104 || idone !== 1'b1) begin n_err++; $display("FAIL kill_pre_pc: got %0b/%h want 1/00000104", idone, ins_pc); end
        n_vec++; if (ifetch_addr !== 32'h106) begin n_err++; $display("FAIL kill_pre_addr: got %h want 00000106", ifetch_addr); end
        step(1'b0, 1'b0, 1'b1, 32'h2001);
        n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL kill_redir_idone: got %0b want 0", idone); end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            n_vec++; if (dbg_state !== ST_KILL) begin n_err++; $display("FAIL kill_state%0d: got %0d want %0d", c, dbg_state, ST_KILL); end
            n_vec++; if (ifetch_req !== 1'b1 || ifetch_addr !== 32'h106) begin n_err++; $display("FAIL kill_addr%0d: got %0b/%h want 1/00000106", c, ifetch_req, ifetch_addr); end
            n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL kill_idone%0d: got %0b want 0", c, idone); end
        end
        mem_lat = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL kill_exit_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_vec++; if (ifetch_req !== 1'b1 || ifetch_addr !== 32'h2000) begin n_err++; $display("FAIL kill_new_addr: got %0b/%h want 1/00002000", ifetch_req, ifetch_addr); end
        n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL kill_new_idone: got %0b want 0", idone); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (idone !== 1'b1 || ins_pc !== 32'h2000) begin n_err++; $display("FAIL kill_first_pc: got %0b/%h want 1/00002000", idone, ins_pc); end
        n_vec++; if (ins !== mem_word(32'h2000)) begin n_err++; $display("FAIL kill_first_ins: got %h want %h", ins, mem_word(32'h2000)); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h3000);
        n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL rack_idone: got %0b want 0", idone); end
        mem_lat = 2;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rack_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_vec++; if (ifetch_req !== 1'b1 || ifetch_addr !== 32'h3000) begin n_err++; $display("FAIL rack_addr: got %0b/%h want 1/00003000", ifetch_req, ifetch_addr); end
        n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL rack_empty0: got %0b want 0", idone); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL rack_empty1: got %0b want 0", idone); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL rack_empty2: got %0b want 0", idone); end
        mem_lat = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (idone !== 1'b1 || ins_pc !== 32'h3000) begin n_err++; $display("FAIL rack_first_pc: got %0b/%h want 1/00003000", idone, ins_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        n_vec++; if (ifetch_req !== 1'b0 || idone !== 1'b0) begin n_err++; $display("FAIL wrap_redir: got %0b/%0b want 0/0", ifetch_req, idone); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (ifetch_addr !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL wrap_addr0: got %h want fffffffe", ifetch_addr); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (ifetch_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr1: got %h want 00000000", ifetch_addr); end
        n_vec++; if (idone !== 1'b1 || ins_pc !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL wrap_pc0: got %0b/%h want 1/fffffffe", idone, ins_pc); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (idone !== 1'b1 || ins_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc1: got %0b/%h want 1/00000000", idone, ins_pc); end
        n_vec++; if (ifetch_addr !== 32'h2) begin n_err++; $display("FAIL wrap_addr2: got %h want 00000002", ifetch_addr); end
    endtask

    task automatic test_reset_full();
        do_reset();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 32'h0);
        n_vec++; if (ifetch_req !== 1'b0) begin n_err++; $display("FAIL rfull_req: got %0b want 0", ifetch_req); end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        n_vec++; if (idone !== 1'b0 || ifetch_req !== 1'b0) begin n_err++; $display("FAIL rfull_during: got %0b/%0b want 0/0", idone, ifetch_req); end
        step(1'b0, 1'b1, 1'b0, 32'h0);
        n_vec++; if (idone !== 1'b0) begin n_err++; $display("FAIL rfull_idone: got %0b want 0", idone); end
        n_vec++; if (ifetch_req !== 1'b1 || ifetch_addr !== 32'h100) begin n_err++; $display("FAIL rfull_addr: got %0b/%h want 1/00000100", ifetch_req, ifetch_addr); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (idone !== 1'b1 || ins_pc !== 32'h100) begin n_err++; $display("FAIL rfull_pc: got %0b/%h want 1/00000100", idone, ins_pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_kill();
        test_redirect_ack();
        test_wrap();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
